// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider.
// Holds the controller state encoding, the default operand width and a
// helper that sizes the iteration counter.
package div_pkg;

   // Default operand width: divisor, quotient and remainder are N bits.
   localparam int DEF_N = 4;

   // Counter width for the default configuration.
   localparam int DEF_CNT_W = $clog2(DEF_N + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ITER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counter width for an arbitrary operand width n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Compare-and-subtract stage of a restoring divider.
// Latency: combinational.
// Backpressure: none; it is a pure function of its inputs.
// Ports: partial  - N+1 bit partial remainder after the left shift
//        divisor  - N bit unsigned divisor
//        result   - partial minus divisor when it fits, otherwise partial unchanged
//        q_bit    - 1 when the subtraction was taken
module div_sub_stage #(
   parameter int N = 4
) (
   input  logic [N:0]   partial,
   input  logic [N-1:0] divisor,
   output logic [N:0]   result,
   output logic         q_bit
);

   logic [N:0] dvr_ext;

   assign dvr_ext = {1'b0, divisor};
   assign q_bit   = (partial >= dvr_ext);
   assign result  = q_bit ? (partial - dvr_ext) : partial;

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Latency: done pulses N+1 cycles after the accepting edge (1 cycle when the quotient overflows).
// Backpressure: st is only honoured in IDLE; starts while busy are dropped, not queued.
// Ports: clk, rst (async, active-high); dividend_i/divisor_i sampled when st is accepted;
//        quotient_o/remainder_o/ov registered results; done one-cycle completion pulse;
//        busy (only when DIV_BUSY_EN is defined) high during CHECK and ITER.
module shift_sub_divider
   import div_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [2*N-1:0] dividend_i,
   input  logic [N-1:0]   divisor_i,
   input  logic           st,
   output logic [N-1:0]   quotient_o,
   output logic [N-1:0]   remainder_o,
   output logic           ov,
   output logic           done
`ifdef DIV_BUSY_EN
   ,
   output logic           busy
`endif
);

   localparam int CW = cnt_width(N);

   state_t        state;
   logic [2*N:0]  acc;
   logic [N-1:0]  dvr;
   logic [CW-1:0] cnt;

   logic [2*N:0]  shifted;
   logic [2*N:0]  acc_nxt;
   logic [N:0]    stage_res;
   logic          stage_q;
   logic          last_step;
   logic          busy_q;

   // The upper N+1 bits of the shifted accumulator form the partial remainder.
   always_comb shifted = acc << 1;

   div_sub_stage #(.N(N)) u_stage (
      .partial (shifted[2*N:N]),
      .divisor (dvr),
      .result  (stage_res),
      .q_bit   (stage_q)
   );

   // The freshly shifted-in LSB becomes the new quotient bit.
   always_comb begin
      acc_nxt        = shifted;
      acc_nxt[2*N:N] = stage_res;
      acc_nxt[0]     = stage_q;
   end

   assign last_step = (cnt == CW'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         dvr         <= '0;
         cnt         <= '0;
         quotient_o  <= '0;
         remainder_o <= '0;
         ov          <= 1'b0;
         done        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (st) begin
                  acc    <= {1'b0, dividend_i};
                  dvr    <= divisor_i;
                  busy_q <= 1'b1;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               // A quotient fits in N bits only if the upper half is below the divisor;
               // a zero divisor always fails this test.
               if ((dvr == '0) || (acc[2*N-1:N] >= dvr)) begin
                  ov          <= 1'b1;
                  quotient_o  <= '0;
                  remainder_o <= '0;
                  done        <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= DONE;
               end else begin
                  ov    <= 1'b0;
                  cnt   <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (last_step) begin
                  quotient_o  <= acc_nxt[N-1:0];
                  remainder_o <= acc_nxt[2*N-1:N];
                  done        <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DIV_BUSY_EN
   assign busy = busy_q;
`else
   // Without the busy port the flag is unused; fold it in harmlessly.
   logic unused_busy;
   assign unused_busy = busy_q;
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
module tb_shift_sub_divider;

   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic [2*N-1:0] dividend_i;
   logic [N-1:0]   divisor_i;
   logic           st;
   logic [N-1:0]   quotient_o;
   logic [N-1:0]   remainder_o;
   logic           ov;
   logic           done;
`ifdef DIV_BUSY_EN
   logic           busy;
`endif

   int nvec = 0;
   int nerr = 0;

   shift_sub_divider #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .st          (st),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o),
      .ov          (ov),
      .done        (done)
`ifdef DIV_BUSY_EN
      ,
      .busy        (busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int dd;
      int dv;
      int q;
      int r;
      int ov;
      int lat;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer division with the N-bit quotient limit.
   task automatic model(input int dd, input int dv,
                        output int q, output int r, output int o, output int lat);
      if (dv == 0 || (dd / dv) > (2**N - 1)) begin
         q = 0; r = 0; o = 1; lat = 1;
      end else begin
         q = dd / dv; r = dd % dv; o = 0; lat = N + 1;
      end
   endtask

   // One division with st pulsed for a single cycle; operands are scrambled
   // after acceptance. lat counts edges after the accepting edge until done.
   task automatic run_div(input int dd, input int dv,
                          output int q, output int r, output int o,
                          output int lat, output int width, output int bcnt);
      dividend_i = (2*N)'(dd);
      divisor_i  = N'(dv);
      st = 1'b1;
      step();
      st = 1'b0;
      lat = -1; width = 0; bcnt = 0; q = -1; r = -1; o = -1;
`ifdef DIV_BUSY_EN
      if (busy) bcnt++;
`endif
      for (int c = 1; c <= 30; c++) begin
         dividend_i = (2*N)'($urandom);
         divisor_i  = N'($urandom);
         step();
`ifdef DIV_BUSY_EN
         if (busy) bcnt++;
`endif
         if (done) begin
            lat = c;
            q = int'(quotient_o); r = int'(remainder_o); o = int'(ov);
            break;
         end
      end
      if (lat > 0) begin
         step();
         width = done ? 2 : 1;
      end
   endtask

   task automatic check_div(input string tag, input int dd, input int dv,
                            input int eq, input int er, input int eo, input int el);
      int q, r, o, lat, width, bcnt;
      run_div(dd, dv, q, r, o, lat, width, bcnt);
      check({tag, " quotient"}, q, eq);
      check({tag, " remainder"}, r, er);
      check({tag, " ov"}, o, eo);
      check({tag, " latency"}, lat, el);
      check({tag, " done width"}, width, 1);
`ifdef DIV_BUSY_EN
      check({tag, " busy cycles"}, bcnt, (eo != 0) ? 1 : N + 1);
`endif
   endtask

   initial begin
      int q, r, o, lat, dd, dv, pulses, lat1, lat2;

      tbl[0] = '{dd: 77,  dv: 7,  q: 11, r: 0,  ov: 0, lat: N + 1};
      tbl[1] = '{dd: 135, dv: 13, q: 10, r: 5,  ov: 0, lat: N + 1};
      tbl[2] = '{dd: 239, dv: 15, q: 15, r: 14, ov: 0, lat: N + 1};
      tbl[3] = '{dd: 200, dv: 5,  q: 0,  r: 0,  ov: 1, lat: 1};
      tbl[4] = '{dd: 50,  dv: 0,  q: 0,  r: 0,  ov: 1, lat: 1};
      tbl[5] = '{dd: 0,   dv: 1,  q: 0,  r: 0,  ov: 0, lat: N + 1};
      tbl[6] = '{dd: 15,  dv: 1,  q: 15, r: 0,  ov: 0, lat: N + 1};
      tbl[7] = '{dd: 16,  dv: 1,  q: 0,  r: 0,  ov: 1, lat: 1};

      rst = 1'b1; st = 1'b0; dividend_i = '0; divisor_i = '0;
      step(); step();
      check("reset quotient", int'(quotient_o), 0);
      check("reset remainder", int'(remainder_o), 0);
      check("reset ov", int'(ov), 0);
      check("reset done", int'(done), 0);
`ifdef DIV_BUSY_EN
      check("reset busy", int'(busy), 0);
`endif
      rst = 1'b0;
      step();

      foreach (tbl[i])
         check_div($sformatf("vec%0d %0d/%0d", i, tbl[i].dd, tbl[i].dv),
                   tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, tbl[i].ov, tbl[i].lat);

      // Reset during the second ITER cycle, with non-zero outputs beforehand.
      check_div("pre-reset 135/13", 135, 13, 10, 5, 0, N + 1);
      dividend_i = 8'd77; divisor_i = 4'd7; st = 1'b1;
      step();            // accepted, now in CHECK
      st = 1'b0;
      step();            // now first ITER cycle
      step();            // now second ITER cycle
      rst = 1'b1;
      #1;
      check("midreset quotient", int'(quotient_o), 0);
      check("midreset remainder", int'(remainder_o), 0);
      check("midreset ov", int'(ov), 0);
      check("midreset done", int'(done), 0);
      step();
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (done) pulses++;
      end
      check("midreset no done pulse", pulses, 0);
      check_div("post-reset 77/7", 77, 7, 11, 0, 0, N + 1);

      // st held high throughout, operands changing every cycle.
      dividend_i = 8'd77; divisor_i = 4'd7; st = 1'b1;
      step();
      lat1 = -1;
      for (int c = 1; c <= 30; c++) begin
         dividend_i = (2*N)'($urandom);
         divisor_i  = N'($urandom);
         step();
         if (done) begin
            lat1 = c; q = int'(quotient_o); r = int'(remainder_o); o = int'(ov);
            break;
         end
      end
      check("held-st latency", lat1, N + 1);
      check("held-st quotient", q, 11);
      check("held-st remainder", r, 0);
      check("held-st ov", o, 0);
      // The next start is only taken once DONE has returned to IDLE.
      dividend_i = 8'd135; divisor_i = 4'd13;
      lat2 = -1;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (done) begin
            lat2 = c; q = int'(quotient_o); r = int'(remainder_o);
            break;
         end
      end
      st = 1'b0;
      check("back-to-back spacing", lat2, N + 3);
      check("back-to-back quotient", q, 10);
      check("back-to-back remainder", r, 5);
      step(); step(); step();

      // Random divisions against the reference model.
      for (int i = 0; i < 40; i++) begin
         dd = int'($urandom_range(0, 2**(2*N) - 1));
         dv = int'($urandom_range(0, 2**N - 1));
         model(dd, dv, q, r, o, lat);
         check_div($sformatf("rand %0d/%0d", dd, dv), dd, dv, q, r, o, lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
- Sequential restoring divider: 2N-bit unsigned dividend / N-bit unsigned divisor -> N-bit quotient + N-bit remainder, one quotient bit per clock.
- Inverse companion of the team's shift-add multiplier; uses the same st/done start-complete handshake.
- Flags overflow when the quotient cannot fit in N bits, including divide-by-zero.

Parameters:
- N, 4, operand width: divisor, quotient and remainder are N bits; dividend is 2N bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dividend_i  input  2N  unsigned dividend; sampled only when a start is accepted.
- divisor_i  input  N  unsigned divisor; sampled with dividend_i.
- st  input  1  start request; honoured only in IDLE.
- quotient_o  output  N  registered quotient.
- remainder_o  output  N  registered remainder.
- ov  output  1  registered overflow flag.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE; quotient_o=0, remainder_o=0, ov=0, done=0; internal accumulator and counter cleared.
  - Takes effect immediately (async), including mid-operation; the in-flight division is abandoned with no done pulse.
- States:
  - IDLE: on an edge with st=1, latch dividend into a 2N+1-bit accumulator ACC (MSB=0), latch divisor into DVR, go to CHECK. With st=0, stay.
  - CHECK (one cycle): if DVR==0 or ACC[2N-1:N] >= DVR, set ov=1, quotient_o=0, remainder_o=0, go to DONE. Otherwise set ov=0, counter=0, go to ITER.
  - ITER: each edge:
    - shift ACC left 1;
    - if ACC[2N:N] (after shift) >= DVR, replace ACC[2N:N] with ACC[2N:N]-DVR and set ACC[0]=1; else ACC[0]=0;
    - counter++.
    - After the Nth step, load quotient_o=ACC[N-1:0] and remainder_o=ACC[2N-1:N], go to DONE.
  - DONE: done=1 for exactly this one cycle; always returns to IDLE.
- Latency from the edge that accepts st:
  - normal: done high in the cycle after edge k+N+1;
  - overflow: done high in the cycle after edge k+1.
- Outputs hold their values from done until the next CHECK/ITER completion; they are not cleared by a new start.
- st is ignored in CHECK, ITER and DONE; there is no queuing. A back-to-back start requires st high in IDLE.
- Operand inputs may change freely after acceptance without affecting the result.
- Arithmetic widths:
  - subtractor is N+1 bits;
  - comparison is unsigned;
  - remainder is always < divisor when ov=0.

Optional Feature:
- Macro DIV_BUSY_EN.
- Defined: adds output port busy (1 bit), reset 0. busy is high in CHECK and ITER, low in IDLE and DONE.
- Undefined: no busy port; all other behaviour is identical.

Decomposition:
- Shared package div_pkg:
  - state enum IDLE/CHECK/ITER/DONE (2-bit encoding);
  - default N constant;
  - counter width localparam $clog2(N+1).
- One natural sub-module, div_sub_stage: combinational N+1-bit compare-and-subtract producing the difference and the quotient bit; the FSM, registers and counter stay in the top.

Test Plan:
- Reset mid-ITER: assert rst during the 2nd ITER cycle -> all outputs 0 at once, state IDLE, no done pulse; a following 77/7 completes correctly.
- 77 / 7 (N=4): st pulse one cycle -> done after N+1 cycles, quotient_o=11, remainder_o=0, ov=0; done high exactly one cycle.
- 135 / 13 -> quotient_o=10, remainder_o=5, ov=0.
- 239 / 15 (max non-overflow) -> quotient_o=15, remainder_o=14, ov=0.
- Overflow and divide-by-zero:
  - 200 / 5 -> ov=1, quotient_o=0, remainder_o=0, done one cycle after CHECK;
  - 50 / 0 -> ov=1 with the same timing.
- st held high through CHECK/ITER and operands changed mid-operation -> result matches the operands latched at acceptance; a second division starts only after DONE returns to IDLE. With DIV_BUSY_EN, busy is high for exactly N+1 cycles.
